nothing_pipe: RTL

Parametrised successor to the pass-through "nothing" block: carries data/nd/metadata through a configurable DELAY-stage pipeline. Adds a message-port command interface: enable/disable the stream, clear, or report the sample count. Reports go out on the out_msg stream; a sticky error flag is raised. Sits in the sdrlib chain as a latency-matching and diagnostic stage.

---
 rtl/nothing_pkg.sv | 20 ++
 rtl/nothing_delay_stage.sv | 26 ++
 rtl/nothing_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/nothing_pkg.sv
// Shared constants for the nothing_pipe latency/diagnostic stage.
package nothing_pkg;

  // Command opcodes, taken from the top two bits of the command word
  localparam logic [1:0] OP_REPORT = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET_EN = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  // Tag in the top two bits of a report header word
  localparam logic [1:0] HDR_TAG = 2'b01;

  // Report sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HDR  = 2'b01,
    CNT  = 2'b10
  } state_e;

endpackage

// File: rtl/nothing_delay_stage.sv
// One valid-tagged pipeline register; payload only loads on a valid beat.
module nothing_delay_stage #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  input  logic         v,
  output logic [W-1:0] q,
  output logic         q_v
);

  // Valid always shifts; payload holds the last delivered value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      q_v <= 1'b0;
    end else begin
      q_v <= v;
      if (v) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/nothing_pipe.sv
// Fixed-latency sample pipe with a command port for enable/clear/count reports.
module nothing_pipe
  import nothing_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MWIDTH    = 1,
  parameter int unsigned MSG_WIDTH = 32,
  parameter int unsigned DELAY     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_nd,
  input  logic [MWIDTH-1:0]    in_m,
  input  logic [MSG_WIDTH-1:0] in_msg,
  input  logic                 in_msg_nd,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_nd,
  output logic [MWIDTH-1:0]    out_m,
  output logic [MSG_WIDTH-1:0] out_msg,
  output logic                 out_msg_nd,
  output logic                 error
);

  localparam int unsigned PW = WIDTH + MWIDTH;
  localparam logic [7:0]  DELAY_TAG = 8'(DELAY);
  localparam logic [MSG_WIDTH-1:0] HDR_WORD =
    {HDR_TAG, {(MSG_WIDTH-10){1'b0}}, DELAY_TAG};

  state_e                 state_q, state_d;
  logic [MSG_WIDTH-1:0]   count_q;
  logic [MSG_WIDTH-1:0]   snap_q;
  logic                   enable_q;

  logic [MSG_WIDTH-1:0]   msg_d;
  logic                   msg_nd_d;
  logic                   snap_ld;
  logic                   clr;
  logic                   en_ld;
  logic                   rsvd;
  logic                   drop;
  logic                   accept;
  logic                   wrap;
  logic                   err_set;
  logic [1:0]             op;

  logic [PW-1:0]          stg_d [0:DELAY];
  logic                   stg_v [0:DELAY];

  assign accept = in_nd & enable_q;
  assign op     = in_msg[MSG_WIDTH-1 -: 2];

  // Pipeline entry: only accepted samples become valid
  assign stg_d[0] = {in_m, in_data};
  assign stg_v[0] = accept;

  for (genvar k = 0; k < DELAY; k++) begin : g_stage
    nothing_delay_stage #(.W(PW)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (stg_d[k]),
      .v     (stg_v[k]),
      .q     (stg_d[k+1]),
      .q_v   (stg_v[k+1])
    );
  end

  // Outputs come straight from the final stage register
  assign out_data = stg_d[DELAY][WIDTH-1:0];
  assign out_m    = stg_d[DELAY][PW-1:WIDTH];
  assign out_nd   = stg_v[DELAY];

  // Report sequencer next-state, command decode and next report word
  always_comb begin
    state_d  = state_q;
    msg_d    = '0;
    msg_nd_d = 1'b0;
    snap_ld  = 1'b0;
    clr      = 1'b0;
    en_ld    = 1'b0;
    rsvd     = 1'b0;
    drop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_msg_nd) begin
          case (op)
            OP_REPORT: begin
              state_d  = HDR;
              msg_d    = HDR_WORD;
              msg_nd_d = 1'b1;
              snap_ld  = 1'b1;
            end
            OP_CLEAR:  clr   = 1'b1;
            OP_SET_EN: en_ld = 1'b1;
            default:   rsvd  = 1'b1;
          endcase
        end
      end
      HDR: begin
        state_d  = CNT;
        msg_d    = snap_q;
        msg_nd_d = 1'b1;
        drop     = in_msg_nd;
      end
      CNT: begin
        state_d = IDLE;
        drop    = in_msg_nd;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter wrap is suppressed by a same-cycle clear (count restarts instead)
  assign wrap    = accept & (&count_q) & ~clr;
  assign err_set = wrap | rsvd | drop;

  // Sequencer state and registered report outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      out_msg    <= '0;
      out_msg_nd <= 1'b0;
      snap_q     <= '0;
    end else begin
      state_q    <= state_d;
      out_msg    <= msg_d;
      out_msg_nd <= msg_nd_d;
      if (snap_ld) begin
        snap_q <= count_q;
      end
    end
  end

  // Sample counter, stream enable and sticky error (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      enable_q <= 1'b1;
      error    <= 1'b0;
    end else begin
      if (clr) begin
        count_q <= MSG_WIDTH'(accept);
      end else if (accept) begin
        count_q <= count_q + MSG_WIDTH'(1);
      end
      if (en_ld) begin
        enable_q <= in_msg[0];
      end
      error <= err_set | (error & ~clr);
    end
  end

endmodule
